// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing for the Pong renderer: 25 MHz pixel enable from CLOCK_50,
// raster counters, strobes, and a blanked, sync-aligned VGA output register stage.
module vga_timing_gen #(
  parameter logic [9:0] H_ACTIVE     = 10'd640,
  parameter logic [9:0] H_SYNC_START = 10'd660,
  parameter logic [9:0] H_SYNC_END   = 10'd756,
  parameter logic [9:0] H_TOTAL      = 10'd800,
  parameter logic [9:0] V_ACTIVE     = 10'd480,
  parameter logic [9:0] V_SYNC_START = 10'd494,
  parameter logic [9:0] V_SYNC_END   = 10'd495,
  parameter logic [9:0] V_TOTAL      = 10'd525
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  output logic        pix_en,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        active,
  output logic        line_start,
  output logic        frame_end,
  input  logic [11:0] rgb_in,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  logic phase;
  logic h_last;
  logic v_last;
  logic hs_raw;
  logic vs_raw;

  // pix_en trails phase by one edge, so the first enable lands on the second edge after reset
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      phase  <= 1'b0;
      pix_en <= 1'b0;
    end else begin
      phase  <= ~phase;
      pix_en <= phase;
    end
  end

  assign h_last = (h_count == H_TOTAL - 10'd1);
  assign v_last = (v_count == V_TOTAL - 10'd1);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  always_comb begin
    active     = (h_count < H_ACTIVE) && (v_count < V_ACTIVE);
    line_start = pix_en && (h_count == 10'd0);
    frame_end  = pix_en && h_last && v_last;
    hs_raw     = !((h_count >= H_SYNC_START) && (h_count <= H_SYNC_END));
    vs_raw     = !((v_count >= V_SYNC_START) && (v_count <= V_SYNC_END));
  end

  // colour and syncs share one register stage so they stay pixel-aligned at the pins
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (pix_en) begin
      VGA_R  <= active ? rgb_in[11:8] : 4'd0;
      VGA_G  <= active ? rgb_in[7:4]  : 4'd0;
      VGA_B  <= active ? rgb_in[3:0]  : 4'd0;
      VGA_HS <= hs_raw;
      VGA_VS <= vs_raw;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; vertical timing is shortened (10 lines/frame)
// so whole frames fit in a short run while horizontal timing stays at full size.
module tb_vga_timing_gen;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        pix_en;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        active;
  logic        line_start;
  logic        frame_end;
  logic [11:0] rgb_in = 12'hFFF;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_gen #(
    .V_ACTIVE(10'd6), .V_SYNC_START(10'd7), .V_SYNC_END(10'd8), .V_TOTAL(10'd10)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .pix_en(pix_en), .h_count(h_count),
    .v_count(v_count), .active(active), .line_start(line_start), .frame_end(frame_end),
    .rgb_in(rgb_in), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // steps until (h,v,pix_en) matches; the final check catches an expired budget
  task automatic wait_hv(input string tag, input int h, input int v, input int pe,
                         input int budget, output int n);
    n = 0;
    while (!(h_count == h && v_count == v && pix_en == pe) && n < budget) begin
      step();
      n++;
    end
    check(tag, {h_count, v_count, pix_en}, {h[9:0], v[9:0], pe[0]});
  endtask

  initial begin
    int n;
    int cnt;
    int fe_cnt;
    int fe_at;
    int max_h;
    int max_v;

    repeat (3) step();
    check("rst_pix_en", pix_en, 0);
    check("rst_h", h_count, 0);
    check("rst_v", v_count, 0);
    check("rst_hs", VGA_HS, 1);
    check("rst_vs", VGA_VS, 1);
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("rst_strobes", {line_start, frame_end}, 0);

    RESET = 1'b0;
    step();
    check("pe_first_cycle", pix_en, 0);
    step();
    check("pe_second_cycle", pix_en, 1);
    check("ls_first", line_start, 1);
    step();
    check("first_pixel_rgb", {VGA_R, VGA_G, VGA_B}, 12'hFFF);
    check("h_after_first", h_count, 1);

    wait_hv("reach_799", 799, 0, 1, 2000, n);
    check("cycles_to_799", n, 1597);
    step();
    check("wrap_hv", {h_count, v_count}, {10'd0, 10'd1});
    step();
    check("ls_line1", line_start, 1);
    wait_hv("reach_line2", 0, 2, 1, 2000, n);
    check("line_period", n, 1600);

    // horizontal sync
    wait_hv("reach_h660", 660, 2, 0, 2000, n);
    step();
    check("hs_before", VGA_HS, 1);
    step();
    check("hs_first_low", VGA_HS, 0);
    cnt = 0;
    while (VGA_HS == 1'b0 && cnt < 400) begin
      cnt++;
      step();
    end
    check("hs_low_cycles", cnt, 194);

    // vertical sync (lines 7..8 in the shortened frame)
    wait_hv("reach_v7", 0, 7, 0, 10000, n);
    step();
    check("vs_before", VGA_VS, 1);
    step();
    check("vs_first_low", VGA_VS, 0);
    cnt = 0;
    while (VGA_VS == 1'b0 && cnt < 4000) begin
      cnt++;
      step();
    end
    check("vs_low_cycles", cnt, 3200);

    // frame_end: one pulse per 16000 cycles, at (799,9)
    wait_hv("reach_frame_end", 799, 9, 1, 4000, n);
    check("fe_at_end", frame_end, 1);
    check("ls_at_end", line_start, 0);
    fe_cnt = 0;
    fe_at = 0;
    max_h = 0;
    max_v = 0;
    for (int i = 1; i <= 16000; i++) begin
      step();
      if (frame_end) begin
        fe_cnt++;
        fe_at = i;
      end
      if (frame_end && !pix_en) fe_cnt += 100;
      if (h_count > max_h) max_h = h_count;
      if (v_count > max_v) max_v = v_count;
      if (i == 2) check("ls_after_fe", {line_start, h_count, v_count}, {1'b1, 10'd0, 10'd0});
    end
    check("fe_pulses", fe_cnt, 1);
    check("fe_period", fe_at, 16000);
    check("fe_hv", {h_count, v_count}, {10'd799, 10'd9});
    check("max_h", max_h, 799);
    check("max_v", max_v, 9);

    // blanking with a magenta input
    rgb_in = 12'hF0F;
    wait_hv("reach_h10", 10, 1, 0, 4000, n);
    step();
    step();
    check("rgb_active", {VGA_R, VGA_G, VGA_B}, 12'hF0F);
    wait_hv("reach_h639", 639, 1, 0, 2000, n);
    step();
    step();
    check("rgb_h639", {VGA_R, VGA_G, VGA_B}, 12'hF0F);
    step();
    step();
    check("rgb_h640_blank", {VGA_R, VGA_G, VGA_B}, 12'h000);

    // rgb_in changes between enables are not sampled
    wait_hv("reach_h200", 200, 2, 0, 4000, n);
    rgb_in = 12'h123;
    step();
    rgb_in = 12'hABC;
    step();
    check("rgb_sampled_on_pe", {VGA_R, VGA_G, VGA_B}, 12'hABC);
    rgb_in = 12'h456;
    step();
    check("r_hold_off_pe", VGA_R, 4'hA);
    rgb_in = 12'h789;
    step();
    check("r_next_pe", VGA_R, 4'h7);

    rgb_in = 12'hFFF;
    wait_hv("reach_blank_line", 100, 7, 0, 12000, n);
    step();
    step();
    check("rgb_blank_line", {VGA_R, VGA_G, VGA_B}, 12'h000);

    // reset mid-line inside the horizontal sync pulse
    wait_hv("reach_h700", 700, 3, 1, 20000, n);
    check("hs_low_pre_reset", VGA_HS, 0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("mid_rst_hv", {h_count, v_count}, 0);
    check("mid_rst_sync", {VGA_HS, VGA_VS}, 2'b11);
    check("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("mid_rst_pe", pix_en, 0);
    step();
    check("resume_pe0", pix_en, 0);
    step();
    check("resume_pe1", {pix_en, line_start, h_count}, {1'b1, 1'b1, 10'd0});
    step();
    check("resume_h1", {h_count, VGA_HS, VGA_R}, {10'd1, 1'b1, 4'hF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
